// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction decode controller:
// op/ext codes, FSM encoding, field positions and the decoded-field bundle.
package isa_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_CMP  = 4'b1011;
  localparam logic [3:0] ALU_MOV  = 4'b1101;
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LDX   = 4'b0100;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int EXT_LSB = 4;
  localparam int RS_LSB  = 0;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [15:0] imm16;
    logic        wsel;
    logic        no_write;
    logic        illegal;
  } dec_t;

  function automatic logic is_alu(input logic [3:0] c);
    return c == ALU_AND || c == ALU_OR  || c == ALU_XOR || c == ALU_ADD ||
           c == ALU_SUB || c == ALU_CMP || c == ALU_MOV;
  endfunction

  // Arithmetic ops take a signed immediate; logical ops and MOV take it raw.
  function automatic logic is_signed_op(input logic [3:0] c);
    return c == ALU_ADD || c == ALU_SUB || c == ALU_CMP;
  endfunction
endpackage

// File: rtl/instr_decode_ctrl_if.sv
// Instruction handshake plus datapath control bundle of the decode controller.
interface instr_decode_ctrl_if #(parameter int RET_W = 16);
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       opcode;
  logic [3:0]       rdest;
  logic [3:0]       rsrc;
  logic [15:0]      regEnable;
  logic             regFileWriteEnable;
  logic [15:0]      immediate;
  logic             useImmediate;
  logic             illegal;
  logic [RET_W-1:0] retired;

  // master: instruction source / datapath side; slave: the controller
  modport master (
    output instr, instr_valid,
    input  instr_ready, opcode, rdest, rsrc, regEnable, regFileWriteEnable,
           immediate, useImmediate, illegal, retired
  );
  modport slave (
    input  instr, instr_valid,
    output instr_ready, opcode, rdest, rsrc, regEnable, regFileWriteEnable,
           immediate, useImmediate, illegal, retired
  );
endinterface

// File: rtl/instr_decoder.sv
// Pure combinational instruction decoder: instr word -> decoded control bundle.
module instr_decoder
  import isa_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);
  logic [3:0] op, ext;
  logic [7:0] imm8;

  assign op   = instr[OP_LSB +: 4];
  assign ext  = instr[EXT_LSB +: 4];
  assign imm8 = instr[7:0];

  always_comb begin
    dec = '0;
    if (op == OP_RTYPE) begin
      if (is_alu(ext)) begin
        dec.alu_op   = ext;
        dec.no_write = (ext == ALU_CMP);
      end else begin
        dec.illegal = 1'b1;
      end
    end else if (op == OP_LDX && ext == 4'b0000) begin
      dec.wsel = 1'b1;
    end else if (is_alu(op)) begin
      dec.alu_op   = op;
      dec.use_imm  = 1'b1;
      dec.imm16    = is_signed_op(op) ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};
      dec.no_write = (op == ALU_CMP);
    end else begin
      dec.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle decode controller: IDLE -> DECODE -> EXEC -> WB, driving the
// register-file/ALU datapath controls and counting retired instructions.
module instr_decode_ctrl
  import isa_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_decode_ctrl_if.slave  bus
);
  logic [1:0]       st;
  logic [15:0]      ir;
  dec_t             dec;
  logic [3:0]       opcode_q, rdest_q, rsrc_q;
  logic [15:0]      imm_q;
  logic             useimm_q, wsel_q, nowr_q;
  logic [RET_W-1:0] ret_q;

  instr_decoder u_dec (.instr(ir), .dec(dec));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= S_IDLE;
      ir       <= '0;
      opcode_q <= '0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      imm_q    <= '0;
      useimm_q <= 1'b0;
      wsel_q   <= 1'b0;
      nowr_q   <= 1'b0;
      ret_q    <= '0;
    end else begin
      case (st)
        S_IDLE: if (bus.instr_valid) begin
          ir <= bus.instr;
          st <= S_DECODE;
        end
        S_DECODE: begin
          // Illegal words leave the visible fields untouched and bail out.
          if (dec.illegal) begin
            st <= S_IDLE;
          end else begin
            opcode_q <= dec.alu_op;
            rdest_q  <= ir[RD_LSB +: 4];
            rsrc_q   <= ir[RS_LSB +: 4];
            imm_q    <= dec.imm16;
            useimm_q <= dec.use_imm;
            wsel_q   <= dec.wsel;
            nowr_q   <= dec.no_write;
            st       <= S_EXEC;
          end
        end
        S_EXEC: st <= S_WB;
        default: begin
          ret_q <= ret_q + 1'b1;
          st    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready        = (st == S_IDLE);
  assign bus.illegal            = (st == S_DECODE) && dec.illegal;
  assign bus.opcode             = opcode_q;
  assign bus.rdest              = rdest_q;
  assign bus.rsrc               = rsrc_q;
  assign bus.immediate          = imm_q;
  assign bus.useImmediate       = useimm_q;
  assign bus.regFileWriteEnable = wsel_q && (st == S_EXEC || st == S_WB);
  // CMP only updates flags, so it never strobes a register.
  assign bus.regEnable          = (st == S_WB && !nowr_q) ? (16'd1 << rdest_q) : 16'd0;
  assign bus.retired            = ret_q;
endmodule
